lcd_fb_arbiter: RTL
===================

Name: lcd_fb_arbiter

Overview:
Owns the 32-character LCD frame buffer and shares write access to it between two requesters, e.g. a status writer and a debug writer.
- Registered fixed-priority-free round-robin arbitration; one character write per cycle maximum.
- Supports a sequenced buffer clear.
- Schedules a one-cycle refresh pulse once writes have settled. The pulse drives the LCD module's restart/reload input, and oFB drives its 256-bit frame-buffer input.

Parameters:
HOLDOFF, 1000, quiet cycles after the last buffer write before a refresh may issue (>=2)
CW, 16, width of the holdoff counter (2^CW > HOLDOFF)
BLANK, 8'h20, character written by reset and by the clear sequence

Ports:
iCLK  in  1  system clock
iRST_N  in  1  reset, asynchronous, active-low
iREQ0  in  1  requester 0 write request; held with iADDR0/iCHAR0 stable until oGNT0
iADDR0  in  5  requester 0 character position (0-15 line 1, 16-31 line 2)
iCHAR0  in  8  requester 0 character code
oGNT0  out  1  one-cycle grant; the write has already been committed
iREQ1  in  1  requester 1 request (same rules)
iADDR1  in  5  requester 1 position
iCHAR1  in  8  requester 1 character
oGNT1  out  1  requester 1 grant
iCLR  in  1  pulse: start the clear sequence
iBUSY  in  1  downstream LCD update in progress; refresh is held off while high
oFB  out  256  frame buffer; position a occupies oFB[8a+7:8a]
oDIRTY  out  1  buffer changed since the last refresh pulse
oCLR_BUSY  out  1  clear sequence in progress
oREFRESH  out  1  one-cycle refresh request

Behaviour:
- One clock domain: iCLK. Reset is asynchronous and active-low on iRST_N.
- Reset values:
  - every oFB byte = BLANK
  - oGNT0/1 = 0, oDIRTY = 0, oCLR_BUSY = 0, oREFRESH = 0
  - holdoff counter = 0
  - last-grant pointer = 1, so requester 0 wins first contention
  - FSM = IDLE
- Eligibility: requester n is eligible at an edge if iREQn=1 and oGNTn=0 (prevents a double write while the requester drops its request).
- Arbitration, IDLE state only:
  - exactly one eligible: it wins
  - both eligible: the one not equal to the last-grant pointer wins
- Grant at the edge: write the winner's iCHAR into oFB byte iADDR, set oGNTn=1 for exactly the next cycle, update the pointer, set oDIRTY, reset the holdoff counter to 0.
- Write-to-grant latency is 1 cycle. A requester toggling every cycle with the other idle gets one write per 2 cycles. Two requesters alternating get one write per cycle total.
- FSM states:
  - IDLE: arbitration active; iCLR=1 -> CLEAR with index=0. iCLR beats any request in the same cycle: no grant.
  - CLEAR: oCLR_BUSY=1, no grants. Each cycle write BLANK to byte index, index+1. Once index 31 is written, go to IDLE (32 cycles). oDIRTY set and holdoff counter reset on every clear write. iCLR during CLEAR restarts at index 0.
- Requests pending during CLEAR are served in IDLE after the clear completes, with normal round-robin. Data is never lost, and grants never occur mid-clear.
- Refresh scheduler, runs in parallel with the FSM:
  - counter increments while oDIRTY=1 and it is < HOLDOFF-1; it saturates at HOLDOFF-1
  - when counter == HOLDOFF-1, oDIRTY=1, iBUSY=0 and FSM=IDLE: oREFRESH=1 for one cycle, oDIRTY cleared, counter to 0
  - iBUSY=1 or CLEAR holds the request pending indefinitely, with no pulse loss
- Simultaneous write and refresh-issue edge: the write wins. oDIRTY stays 1, the counter restarts, and no oREFRESH is issued that edge.
- oFB changes only at write edges and is stable otherwise. Downstream samples it on oREFRESH.
- Address out of range is impossible (5 bits cover 0-31).
- Reset asserted mid-clear or mid-holdoff returns immediately to the reset values. No refresh is pending after reset.

Test Plan:
1. Reset, then idle for 2*HOLDOFF cycles -> oFB all 8'h20, no grant, oREFRESH never asserts, oDIRTY=0.
2. HOLDOFF=8; iREQ0 addr 5, char 8'h41 -> oGNT0 one cycle after the edge, oFB[47:40]=8'h41, oDIRTY=1. oREFRESH pulses exactly 8 cycles after the write edge, then oDIRTY=0.
3. Both requesters assert continuously, addr0=0 char 'A', addr1=16 char 'B', each dropping req after its grant -> grants in the order 0,1 on consecutive cycles. A repeat with the pointer now 1 still grants 0 first only if 1 was last; alternation is verified over 6 grants.
4. Writes every 4 cycles with HOLDOFF=8 -> no refresh until writes stop, then one pulse HOLDOFF cycles after the last write.
5. iBUSY=1 across holdoff expiry for 20 cycles -> no oREFRESH; pulse on the first cycle after iBUSY falls.
6. Buffer pre-filled with 'X', iCLR pulse with iREQ1 held -> oCLR_BUSY high for 32 cycles, all bytes 8'h20, oGNT1 only after oCLR_BUSY falls, followed by a single refresh.

Source files
------------

// File: rtl/lcd_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_fb_arbiter_if
// Description : Requester, clear and refresh signals for the LCD frame-buffer
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_fb_arbiter_if;
    logic         iREQ0;
    logic [4:0]   iADDR0;
    logic [7:0]   iCHAR0;
    logic         oGNT0;
    logic         iREQ1;
    logic [4:0]   iADDR1;
    logic [7:0]   iCHAR1;
    logic         oGNT1;
    logic         iCLR;
    logic         iBUSY;
    logic [255:0] oFB;
    logic         oDIRTY;
    logic         oCLR_BUSY;
    logic         oREFRESH;

    modport master (
        output iREQ0, iADDR0, iCHAR0, iREQ1, iADDR1, iCHAR1, iCLR, iBUSY,
        input  oGNT0, oGNT1, oFB, oDIRTY, oCLR_BUSY, oREFRESH
    );

    modport slave (
        input  iREQ0, iADDR0, iCHAR0, iREQ1, iADDR1, iCHAR1, iCLR, iBUSY,
        output oGNT0, oGNT1, oFB, oDIRTY, oCLR_BUSY, oREFRESH
    );
endinterface
`default_nettype wire

// File: rtl/lcd_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_fb_arbiter
// Description : 32-character LCD frame buffer with round-robin write
//               arbitration, sequenced clear and holdoff-based refresh pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_fb_arbiter #(
    parameter int          HOLDOFF = 1000,
    parameter int          CW      = 16,
    parameter logic [7:0]  BLANK   = 8'h20
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    lcd_fb_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_HOLD_MAX = CW'(HOLDOFF - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_idx;
    logic [4:0]        w_idx_nxt;
    logic [31:0][7:0]  r_fb;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_ptr;
    logic              r_dirty;
    logic [CW-1:0]     r_cnt;
    logic              r_refresh;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_wr_en;
    logic [4:0]        w_wr_addr;
    logic [7:0]        w_wr_data;
    logic              w_gnt0_nxt;
    logic              w_gnt1_nxt;
    logic              w_ptr_nxt;
    logic              w_fire;

    // A requester still showing its grant is ignored, so a held request is not written twice
    assign w_elig0 = bus.iREQ0 & ~r_gnt0;
    assign w_elig1 = bus.iREQ1 & ~r_gnt1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_idx;
        w_wr_data   = BLANK;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (bus.iCLR) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = 5'd0;
                end else if (w_elig0 && (!w_elig1 || r_ptr)) begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = bus.iADDR0;
                    w_wr_data  = bus.iCHAR0;
                    w_gnt0_nxt = 1'b1;
                    w_ptr_nxt  = 1'b0;
                end else if (w_elig1) begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = bus.iADDR1;
                    w_wr_data  = bus.iCHAR1;
                    w_gnt1_nxt = 1'b1;
                    w_ptr_nxt  = 1'b1;
                end
            end
            S_CLEAR: begin
                w_wr_en = 1'b1;
                if (bus.iCLR) begin
                    w_idx_nxt = 5'd0;
                end else if (r_idx == 5'd31) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 5'd0;
                end else begin
                    w_idx_nxt = r_idx + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A write on the same edge as a would-be refresh takes precedence and restarts the holdoff
    assign w_fire = r_dirty && (r_cnt == c_HOLD_MAX) && !bus.iBUSY && (r_state == S_IDLE);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_fb      <= {32{BLANK}};
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_ptr     <= 1'b1;
            r_dirty   <= 1'b0;
            r_cnt     <= '0;
            r_refresh <= 1'b0;
        end else begin
            r_gnt0 <= w_gnt0_nxt;
            r_gnt1 <= w_gnt1_nxt;
            r_ptr  <= w_ptr_nxt;
            if (w_wr_en) begin
                r_fb[w_wr_addr] <= w_wr_data;
                r_dirty         <= 1'b1;
                r_cnt           <= '0;
                r_refresh       <= 1'b0;
            end else if (w_fire) begin
                r_dirty   <= 1'b0;
                r_cnt     <= '0;
                r_refresh <= 1'b1;
            end else begin
                r_refresh <= 1'b0;
                if (r_dirty && (r_cnt < c_HOLD_MAX)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.oFB       = r_fb;
    assign bus.oGNT0     = r_gnt0;
    assign bus.oGNT1     = r_gnt1;
    assign bus.oDIRTY    = r_dirty;
    assign bus.oCLR_BUSY = (r_state == S_CLEAR);
    assign bus.oREFRESH  = r_refresh;

endmodule
`default_nettype wire
